// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Read-source encoding and packed-bus slice helpers live here so the top and read ports agree.
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int MAX_NUM_RD = 4;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_WP0  = 2'd1,
    SRC_WP1  = 2'd2,
    SRC_ZERO = 2'd3
  } rd_src_e;

  // Low bit of slice idx in a bus of w-bit fields packed from bit 0 upward.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  function automatic int slice_hi(input int idx, input int w);
    return (idx * w) + w - 1;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register mux with optional same-cycle write forwarding.
// Reset and the hard-wired zero register override everything else.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           rst_i,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]   regs,
  input  logic [DEPTH-1:0]               busy,
  input  logic                           we0,
  input  logic [ADDR_W-1:0]              wa0,
  input  logic [DATA_W-1:0]              wd0,
  input  logic                           we1,
  input  logic [ADDR_W-1:0]              wa1,
  input  logic [DATA_W-1:0]              wd1,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_busy
);

  rd_src_e src;
  logic    is_zero;

  assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

  // Port 1 is checked first so its data wins when both ports hit this address.
  always_comb begin
    src = SRC_REG;
    if (rst_i || is_zero) begin
      src = SRC_ZERO;
    end else if ((BYPASS != 0) && we1 && (wa1 == rd_addr)) begin
      src = SRC_WP1;
    end else if ((BYPASS != 0) && we0 && (wa0 == rd_addr)) begin
      src = SRC_WP0;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (src)
      SRC_REG:  rd_data = regs[rd_addr];
      SRC_WP0:  rd_data = wd0;
      SRC_WP1:  rd_data = wd1;
      SRC_ZERO: rd_data = '0;
      default:  rd_data = '0;
    endcase
  end

  // Busy reflects registered scoreboard state only; same-cycle writes do not clear it early.
  assign rd_busy = !rst_i && !is_zero && busy[rd_addr];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with a per-register pending-write scoreboard.
// Storage and scoreboard are flops cleared asynchronously by rst_i.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       we0_i,
  input  logic [ADDR_W-1:0]          wa0_i,
  input  logic [DATA_W-1:0]          wd0_i,
  input  logic                       we1_i,
  input  logic [ADDR_W-1:0]          wa1_i,
  input  logic [DATA_W-1:0]          wd1_i,
  input  logic                       rsv_i,
  input  logic [ADDR_W-1:0]          rsv_addr_i,
  output logic [DEPTH-1:0]           busy_vec_o
);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic                         wr0_ok, wr1_ok, rsv_ok;

  // Register 0 is read-only zero when ZERO_REG is set, so its writes and reserves are dropped.
  assign wr1_ok = we1_i && !((ZERO_REG != 0) && (wa1_i == '0));
  assign wr0_ok = we0_i && !((ZERO_REG != 0) && (wa0_i == '0))
                        && !(wr1_ok && (wa1_i == wa0_i));
  assign rsv_ok = rsv_i && !((ZERO_REG != 0) && (rsv_addr_i == '0));

  // Ordering matters: port 1 data overrides port 0, and a reserve overrides a write's clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[wa0_i] = wd0_i;
      busy_d[wa0_i] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[wa1_i] = wd1_i;
      busy_d[wa1_i] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .rst_i   (rst_i),
      .rd_addr (rd_addr_i[slice_lo(k, ADDR_W) +: ADDR_W]),
      .regs    (regs_q),
      .busy    (busy_q),
      .we0     (we0_i),
      .wa0     (wa0_i),
      .wd0     (wd0_i),
      .we1     (we1_i),
      .wa1     (wa1_i),
      .wd1     (wd1_i),
      .rd_data (rd_data_o[slice_lo(k, DATA_W) +: DATA_W]),
      .rd_busy (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: forwarding, write collision, zero register, scoreboard, async reset.
// A second instance with forwarding disabled shares all inputs.
module tb_reg_file_mp;

  localparam int DW = 64;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR*AW-1:0]  rd_addr_i;
  logic [NR*DW-1:0]  rd_data_o, rd_data_nb;
  logic [NR-1:0]     rd_busy_o, rd_busy_nb;
  logic              we0_i, we1_i, rsv_i;
  logic [AW-1:0]     wa0_i, wa1_i, rsv_addr_i;
  logic [DW-1:0]     wd0_i, wd1_i;
  logic [DP-1:0]     busy_vec_o, busy_vec_nb;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_mp #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .we0_i(we0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
    .we1_i(we1_i), .wa1_i(wa1_i), .wd1_i(wd1_i), .rsv_i(rsv_i),
    .rsv_addr_i(rsv_addr_i), .busy_vec_o(busy_vec_o)
  );

  reg_file_mp #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_nb),
    .rd_busy_o(rd_busy_nb), .we0_i(we0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
    .we1_i(we1_i), .wa1_i(wa1_i), .wd1_i(wd1_i), .rsv_i(rsv_i),
    .rsv_addr_i(rsv_addr_i), .busy_vec_o(busy_vec_nb)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we0_i = 1'b0; we1_i = 1'b0; rsv_i = 1'b0;
    wa0_i = '0; wa1_i = '0; rsv_addr_i = '0;
    wd0_i = '0; wd1_i = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr_i[p*AW +: AW] = a;
  endtask

  function automatic logic [63:0] rd(input int p);
    return rd_data_o[p*DW +: DW];
  endfunction

  function automatic logic [63:0] rd_nb(input int p);
    return rd_data_nb[p*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    rd_addr_i = '0;
    idle();

    // Writes presented during reset must be neither forwarded nor stored
    tick();
    we0_i = 1'b1; wa0_i = 5'd5; wd0_i = 64'h1234; set_rd(0, 5'd5);
    #1;
    check("rst_rd_fwd", rd(0), 64'h0);
    check("rst_busy_vec", 64'(busy_vec_o), 64'h0);
    tick();
    idle();
    rst_i = 1'b0;
    #1;

    // All addresses read zero after reset
    for (int a = 0; a < DP; a += 2) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1));
      #1;
      check("reset_rd0", rd(0), 64'h0);
      check("reset_rd1", rd(1), 64'h0);
    end
    check("reset_busy_vec", 64'(busy_vec_o), 64'h0);

    // Same-cycle forwarding on port 0
    tick();
    we0_i = 1'b1; wa0_i = 5'd5; wd0_i = 64'hDEAD_BEEF; set_rd(0, 5'd5);
    #1;
    check("byp_same_cycle", rd(0), 64'hDEAD_BEEF);
    check("nobyp_same_cycle", rd_nb(0), 64'h0);
    tick();
    idle();
    #1;
    check("byp_next_cycle", rd(0), 64'hDEAD_BEEF);
    check("nobyp_next_cycle", rd_nb(0), 64'hDEAD_BEEF);
    check("write_nonbusy_busy5", 64'(busy_vec_o[5]), 64'h0);

    // Both ports to one address: port 1 wins
    we0_i = 1'b1; wa0_i = 5'd7; wd0_i = 64'h11;
    we1_i = 1'b1; wa1_i = 5'd7; wd1_i = 64'h22;
    set_rd(1, 5'd7);
    #1;
    check("collide_fwd", rd(1), 64'h22);
    tick();
    idle();
    #1;
    check("collide_stored", rd(1), 64'h22);
    check("collide_stored_nb", rd_nb(1), 64'h22);

    // Independent forwarding on both ports
    we0_i = 1'b1; wa0_i = 5'd10; wd0_i = 64'h1234;
    we1_i = 1'b1; wa1_i = 5'd11; wd1_i = 64'h5678;
    set_rd(0, 5'd10); set_rd(1, 5'd11);
    #1;
    check("dual_fwd_p0", rd(0), 64'h1234);
    check("dual_fwd_p1", rd(1), 64'h5678);
    tick();
    idle();
    #1;
    check("dual_store_p0", rd_nb(0), 64'h1234);
    check("dual_store_p1", rd_nb(1), 64'h5678);

    // Register 0 stays zero
    we0_i = 1'b1; wa0_i = 5'd0; wd0_i = 64'hFF; set_rd(0, 5'd0);
    #1;
    check("zero_fwd", rd(0), 64'h0);
    tick();
    idle();
    #1;
    check("zero_stored", rd(0), 64'h0);
    check("zero_busy", 64'(busy_vec_o[0]), 64'h0);

    // Scoreboard sequence on address 3
    rsv_i = 1'b1; rsv_addr_i = 5'd3; set_rd(1, 5'd3);
    #1;
    check("rsv_busy_same_cycle", 64'(rd_busy_o[1]), 64'h0);
    tick();
    idle();
    #1;
    check("rsv_busy_vec", 64'(busy_vec_o[3]), 64'h1);
    check("rsv_rd_busy", 64'(rd_busy_o[1]), 64'h1);
    rsv_i = 1'b1; rsv_addr_i = 5'd3;
    we1_i = 1'b1; wa1_i = 5'd3; wd1_i = 64'h44;
    #1;
    check("rsv_wr_fwd", rd(1), 64'h44);
    check("rsv_wr_rd_busy", 64'(rd_busy_o[1]), 64'h1);
    tick();
    idle();
    #1;
    check("rsv_wr_busy", 64'(busy_vec_o[3]), 64'h1);
    check("rsv_wr_data", rd(1), 64'h44);
    we0_i = 1'b1; wa0_i = 5'd3; wd0_i = 64'h55;
    #1;
    check("clear_rd_busy_same", 64'(rd_busy_o[1]), 64'h1);
    tick();
    idle();
    #1;
    check("clear_busy", 64'(busy_vec_o[3]), 64'h0);
    check("clear_data", rd(1), 64'h55);
    tick();
    check("hold_data", rd(1), 64'h55);
    check("hold_busy_vec", 64'(busy_vec_o), 64'h0);

    // Asynchronous reset mid-cycle
    rsv_i = 1'b1; rsv_addr_i = 5'd9;
    we0_i = 1'b1; wa0_i = 5'd9; wd0_i = 64'hAB;
    set_rd(0, 5'd9);
    tick();
    idle();
    #1;
    check("pre_rst_busy9", 64'(busy_vec_o[9]), 64'h1);
    check("pre_rst_data9", rd(0), 64'hAB);
    we1_i = 1'b1; wa1_i = 5'd9; wd1_i = 64'hCD;
    rsv_i = 1'b1; rsv_addr_i = 5'd12;
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_data", rd(0), 64'h0);
    check("async_rst_rd_busy", 64'(rd_busy_o), 64'h0);
    check("async_rst_busy_vec", 64'(busy_vec_o), 64'h0);
    check("async_rst_data3", rd(1), 64'h0);
    idle();
    #1;
    rst_i = 1'b0;
    we0_i = 1'b1; wa0_i = 5'd12; wd0_i = 64'h77;
    set_rd(0, 5'd12); set_rd(1, 5'd3);
    tick();
    idle();
    #1;
    check("first_write_after_rst", rd_nb(0), 64'h77);
    check("old_data_gone", rd(1), 64'h0);
    check("post_rst_busy_vec", 64'(busy_vec_o), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 64: register width in bits.
REQ-002 Parameter DEPTH, default 32: number of registers; power of two, at least 4.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 Parameter NUM_RD, default 2: number of read ports, 1..4.
REQ-005 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-006 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read outputs.
REQ-007 clk_i  in  1  clock; all state changes on the rising edge.
REQ-008 rst_i  in  1  reset; asynchronous, active-high.
REQ-009 rd_addr_i  in  NUM_RD*ADDR_W  read addresses, packed; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-010 rd_data_o  out  NUM_RD*DATA_W  read data, packed the same way.
REQ-011 rd_busy_o  out  NUM_RD  per read port: addressed register has a pending write.
REQ-012 we0_i / wa0_i / wd0_i  in  1 / ADDR_W / DATA_W  write port 0: enable, address, data.
REQ-013 we1_i / wa1_i / wd1_i  in  1 / ADDR_W / DATA_W  write port 1: enable, address, data.
REQ-014 rsv_i / rsv_addr_i  in  1 / ADDR_W  reserve request: marks a register busy because a write to it is pending.
REQ-015 busy_vec_o  out  DEPTH  scoreboard state, one bit per register.

Function
REQ-016 Reads are combinational: rd_data_o[k] = REG[rd_addr_i[k]], subject to REQ-017 and REQ-018.
REQ-017 BYPASS=1: if we1_i is high and wa1_i equals the read address, the port returns wd1_i; else if we0_i is high and wa0_i matches, it returns wd0_i; else it returns REG.
REQ-018 ZERO_REG=1: address 0 reads 0 regardless of bypass or stored state, and its rd_busy_o is 0.
REQ-019 A write with weN_i high updates REG[waN_i] at the rising edge; write latency is 1 cycle.
REQ-020 Both ports write the same address in the same cycle: port 1 wins; port 0 is dropped without error.
REQ-021 ZERO_REG=1: writes to address 0 are ignored and never change the scoreboard.
REQ-022 Scoreboard: rsv_i sets busy[rsv_addr_i] at the clock edge; a write on either port clears busy[waN_i].
REQ-023 Reserve and write to the same address in the same cycle: the set wins, so busy stays 1 and the data is still written.
REQ-024 rsv_i to an already-busy register leaves it busy; a write to a non-busy register leaves it non-busy. The scoreboard holds no counts.
REQ-025 rd_busy_o[k] = busy[rd_addr_i[k]] from the registered state; it is not affected by same-cycle writes.
REQ-026 When no write or reserve is active, all state holds.

Reset
REQ-027 rst_i high clears all registers and all busy bits immediately, without waiting for a clock edge.
REQ-028 While rst_i is high, rd_data_o is 0 for every port and rd_busy_o and busy_vec_o are 0; writes and reserves are ignored.
REQ-029 State after rst_i deasserts is the all-zero state; the first write is accepted on the first rising edge with rst_i low.
REQ-030 Reset asserted in the middle of operation discards all pending writes and reservations.

Structure
REQ-031 The default widths and the packed-port slice helpers belong in the shared package regfile_pkg.
REQ-032 The per-read-port mux plus bypass logic is one sub-module, rf_read_port, instantiated NUM_RD times through a generate loop.
REQ-033 Register storage and scoreboard are flops; no memory macro, no latches.

Verification
REQ-034 Reset, then read all 32 addresses -> every rd_data_o is 0 and busy_vec_o = 0.
REQ-035 we0 to addr 5 with 0xDEAD_BEEF while port 0 reads addr 5 in the same cycle -> BYPASS=1: 0xDEAD_BEEF that cycle; BYPASS=0: 0, then 0xDEAD_BEEF the next cycle.
REQ-036 we0 to addr 7 with 0x11 and we1 to addr 7 with 0x22 in the same cycle -> the next cycle reads 0x22.
REQ-037 Write 0xFF to addr 0 -> reads 0 and busy[0] = 0 (ZERO_REG=1).
REQ-038 rsv addr 3; a later cycle rsv addr 3 plus we1 to addr 3 with 0x44; then we0 to addr 3 with 0x55 -> busy[3] reads 1, 1, 0; data reads 0x44, then 0x55.
REQ-039 Reserve addr 9 and write addr 9 with 0xAB, then assert rst_i asynchronously between clock edges -> the outputs clear that cycle, before the next edge.
